// File: rtl/multicycle_main_ctrl_pkg.sv
// mips_defs: opcodes, ALUOp codes, mux select codes and state encodings shared by the MIPS control blocks.
package mips_defs;
    localparam int ST_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [2:0] ALUOP_NONE  = 3'b000;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_ADD   = 3'b101;
    localparam logic [2:0] ALUOP_SLT   = 3'b110;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [ST_W-1:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADDR = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_REX     = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_IEX     = 4'd11,
        S_IWB     = 4'd12
    } state_t;
endpackage

// File: rtl/multicycle_main_ctrl_if.sv
// multicycle_main_ctrl_if: opcode/memory-ready inputs and datapath control outputs of the main controller.
interface multicycle_main_ctrl_if;
    logic [5:0] instr_op_i;
    logic       mem_ready_i;
    logic       PCWrite_o;
    logic       PCWriteCond_o;
    logic       IorD_o;
    logic       MemRead_o;
    logic       MemWrite_o;
    logic       IRWrite_o;
    logic       MemtoReg_o;
    logic       RegDst_o;
    logic       RegWrite_o;
    logic       ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic [1:0] PCSource_o;
    logic [2:0] ALUOp_o;
    logic       instr_done_o;
    logic       illegal_o;
    logic [3:0] state_o;

    modport master (
        input  instr_op_i, mem_ready_i,
        output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
               MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, PCSource_o,
               ALUOp_o, instr_done_o, illegal_o, state_o
    );

    modport slave (
        output instr_op_i, mem_ready_i,
        input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
               MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, PCSource_o,
               ALUOp_o, instr_done_o, illegal_o, state_o
    );
endinterface

// File: rtl/multicycle_main_ctrl.sv
// multicycle_main_ctrl: Moore main control FSM for the multi-cycle MIPS datapath, stalling on mem_ready.
module multicycle_main_ctrl
    import mips_defs::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    multicycle_main_ctrl_if.master bus
);
    state_t     r_state;
    state_t     w_next;
    logic       w_ready;
    logic [5:0] w_op;

    assign w_ready     = bus.mem_ready_i;
    assign w_op        = bus.instr_op_i;
    assign bus.state_o = r_state;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_RESET;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE:  w_next = (w_op == OP_LW || w_op == OP_SW)     ? S_MEMADDR :
                                (w_op == OP_RTYPE)                    ? S_REX     :
                                (w_op == OP_BEQ)                      ? S_BRANCH  :
                                (w_op == OP_J)                        ? S_JUMP    :
                                (w_op == OP_ADDI || w_op == OP_SLTI) ? S_IEX     : S_FETCH;
            S_MEMADDR: w_next = (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = w_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = w_ready ? S_FETCH : S_MEMWR;
            S_REX:     w_next = S_RWB;
            S_IEX:     w_next = S_IWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        bus.PCWrite_o     = 1'b0;
        bus.PCWriteCond_o = 1'b0;
        bus.IorD_o        = 1'b0;
        bus.MemRead_o     = 1'b0;
        bus.MemWrite_o    = 1'b0;
        bus.IRWrite_o     = 1'b0;
        bus.MemtoReg_o    = 1'b0;
        bus.RegDst_o      = 1'b0;
        bus.RegWrite_o    = 1'b0;
        bus.ALUSrcA_o     = 1'b0;
        bus.ALUSrcB_o     = SRCB_RT;
        bus.PCSource_o    = PCSRC_ALU;
        bus.ALUOp_o       = ALUOP_NONE;
        bus.instr_done_o  = 1'b0;
        bus.illegal_o     = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.MemRead_o = 1'b1;
                bus.ALUSrcB_o = SRCB_FOUR;
                bus.ALUOp_o   = ALUOP_ADD;
                bus.IRWrite_o = w_ready;
                bus.PCWrite_o = w_ready;
            end
            S_DECODE: begin
                // branch target precomputed into ALUOut
                bus.ALUSrcB_o = SRCB_IMM_SH;
                bus.ALUOp_o   = ALUOP_ADD;
                bus.illegal_o = !(w_op == OP_LW || w_op == OP_SW || w_op == OP_RTYPE || w_op == OP_BEQ ||
                                  w_op == OP_J || w_op == OP_ADDI || w_op == OP_SLTI);
            end
            S_MEMADDR: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUSrcB_o = SRCB_IMM;
                bus.ALUOp_o   = ALUOP_ADD;
            end
            S_MEMRD: begin
                bus.MemRead_o = 1'b1;
                bus.IorD_o    = 1'b1;
            end
            S_MEMWB: begin
                bus.RegWrite_o   = 1'b1;
                bus.MemtoReg_o   = 1'b1;
                bus.instr_done_o = 1'b1;
            end
            S_MEMWR: begin
                bus.MemWrite_o   = 1'b1;
                bus.IorD_o       = 1'b1;
                bus.instr_done_o = w_ready;
            end
            S_REX: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUOp_o   = ALUOP_RTYPE;
            end
            S_RWB: begin
                bus.RegWrite_o   = 1'b1;
                bus.RegDst_o     = 1'b1;
                bus.instr_done_o = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA_o     = 1'b1;
                bus.ALUOp_o       = ALUOP_SUB;
                bus.PCWriteCond_o = 1'b1;
                bus.PCSource_o    = PCSRC_ALUOUT;
                bus.instr_done_o  = 1'b1;
            end
            S_JUMP: begin
                bus.PCWrite_o    = 1'b1;
                bus.PCSource_o   = PCSRC_JUMP;
                bus.instr_done_o = 1'b1;
            end
            S_IEX: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUSrcB_o = SRCB_IMM;
                bus.ALUOp_o   = (w_op == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            S_IWB: begin
                bus.RegWrite_o   = 1'b1;
                bus.instr_done_o = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// tb_multicycle_main_ctrl: table-driven, hand-written and randomized checks of the multi-cycle main controller.
module tb_multicycle_main_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    multicycle_main_ctrl_if bus ();
    multicycle_main_ctrl dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

    // Packed output vector: PCW PCWC IORD MR MW IRW M2R RDST RW SRCA SRCB[2] PCSRC[2] ALUOP[3] DONE ILL
    localparam logic [18:0] PCW = 19'h1 << 18, PCWC = 19'h1 << 17, IORD = 19'h1 << 16, MR = 19'h1 << 15;
    localparam logic [18:0] MW = 19'h1 << 14, IRW = 19'h1 << 13, M2R = 19'h1 << 12, RDST = 19'h1 << 11;
    localparam logic [18:0] RW = 19'h1 << 10, SRCA = 19'h1 << 9, SB_4 = 19'h1 << 7, SB_IMM = 19'h2 << 7;
    localparam logic [18:0] SB_SH = 19'h3 << 7, PS_OUT = 19'h1 << 5, PS_J = 19'h2 << 5;
    localparam logic [18:0] AO_SUB = 19'h1 << 2, AO_R = 19'h2 << 2, AO_ADD = 19'h5 << 2, AO_SLT = 19'h6 << 2;
    localparam logic [18:0] DONE = 19'h2, ILL = 19'h1;
    localparam logic [18:0] FR = MR | SB_4 | AO_ADD | IRW | PCW, FS = MR | SB_4 | AO_ADD;
    localparam logic [18:0] DEC = SB_SH | AO_ADD, MA = SRCA | SB_IMM | AO_ADD;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] outs;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [18:0] act_outs();
        return {bus.PCWrite_o, bus.PCWriteCond_o, bus.IorD_o, bus.MemRead_o, bus.MemWrite_o, bus.IRWrite_o,
                bus.MemtoReg_o, bus.RegDst_o, bus.RegWrite_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.PCSource_o,
                bus.ALUOp_o, bus.instr_done_o, bus.illegal_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st, input logic [18:0] o);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.outs = o;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [5:0] op, input logic rdy);
        bus.instr_op_i = op;
        bus.mem_ready_i = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'd0 || op == 6'd2 || op == 6'd4 || op == 6'd8 || op == 6'd10 || op == 6'd35 || op == 6'd43;
    endfunction

    initial begin
        logic [5:0] legal_ops [7];
        legal_ops = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd10, 6'd35, 6'd43};

        add(35, 1, 1, FR); add(35, 1, 2, DEC); add(35, 1, 3, MA); add(35, 1, 4, MR | IORD);
        add(35, 1, 5, RW | M2R | DONE);
        add(0, 1, 1, FR); add(0, 1, 2, DEC); add(0, 1, 7, SRCA | AO_R); add(0, 1, 8, RW | RDST | DONE);
        add(10, 1, 1, FR); add(10, 1, 2, DEC); add(10, 1, 11, SRCA | SB_IMM | AO_SLT); add(10, 1, 12, RW | DONE);
        add(8, 1, 1, FR); add(8, 1, 2, DEC); add(8, 1, 11, SRCA | SB_IMM | AO_ADD); add(8, 1, 12, RW | DONE);
        add(4, 1, 1, FR); add(4, 1, 2, DEC); add(4, 1, 9, SRCA | AO_SUB | PCWC | PS_OUT | DONE);
        add(2, 1, 1, FR); add(2, 1, 2, DEC); add(2, 1, 10, PCW | PS_J | DONE);
        add(43, 1, 1, FR); add(43, 1, 2, DEC); add(43, 1, 3, MA);
        for (int i = 0; i < 3; i++) add(43, 0, 6, MW | IORD);
        add(43, 1, 6, MW | IORD | DONE);
        add(63, 0, 1, FS); add(43, 0, 1, FS); add(35, 1, 1, FR); add(35, 0, 2, DEC); add(35, 0, 3, MA);
        add(35, 0, 4, MR | IORD); add(35, 1, 4, MR | IORD); add(35, 0, 5, RW | M2R | DONE);
        add(63, 1, 1, FR); add(63, 1, 2, DEC | ILL); add(63, 0, 1, FS);

        drive(6'd35, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_state", 32'(bus.state_o), 32'd0);
            chk("reset_outs", 32'(act_outs()), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_state", 32'(bus.state_o), 32'd0);
        next_cycle();

        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_state", i), 32'(bus.state_o), 32'(tbl[i].st));
            chk($sformatf("vec%0d_outs", i), 32'(act_outs()), 32'(tbl[i].outs));
            next_cycle();
        end

        // asynchronous reset while stalled in MEMRD
        for (int i = 0; i < 3; i++) begin drive(6'd35, 1'b1); next_cycle(); end
        drive(6'd35, 1'b0);
        @(negedge clk);
        chk("memrd_before_rst", 32'(bus.state_o), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(bus.state_o), 32'd0);
        chk("async_rst_outs", 32'(act_outs()), 32'd0);
        next_cycle();
        chk("rst_held_state", 32'(bus.state_o), 32'd0);
        rst_n = 1'b1;
        next_cycle();
        chk("post_rst_fetch", 32'(bus.state_o), 32'd1);

        // randomized instructions against a latency/count model
        for (int k = 0; k < 200; k++) begin
            logic [5:0] op;
            int fs, ms, len, mem_start, exp_rw, exp_mw, exp_mr;
            int n_done, n_ill, n_rw, n_mw, n_mr, n_both, n_early_rw, last_done, ill_at;
            bit is_lw, is_sw, legal;
            op = legal_ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end
            legal = is_legal(op);
            is_lw = op == 6'd35;
            is_sw = op == 6'd43;
            fs = $urandom_range(0, 3);
            ms = $urandom_range(0, 3);
            len = !legal ? 2 : is_lw ? 5 : (op == 6'd4 || op == 6'd2) ? 3 : 4;
            len += fs + ((is_lw || is_sw) ? ms : 0);
            mem_start = fs + 3;
            exp_rw = (legal && !is_sw && op != 6'd4 && op != 6'd2) ? 1 : 0;
            exp_mw = is_sw ? ms + 1 : 0;
            exp_mr = fs + 1 + (is_lw ? ms + 1 : 0);
            n_done = 0; n_ill = 0; n_rw = 0; n_mw = 0; n_mr = 0; n_both = 0; n_early_rw = 0;
            last_done = 0; ill_at = -1;
            for (int c = 0; c < len; c++) begin
                logic rdy;
                rdy = 1'($urandom);
                if (c <= fs) rdy = (c == fs);
                else if ((is_lw || is_sw) && c >= mem_start && c <= mem_start + ms) rdy = (c == mem_start + ms);
                drive(c <= fs ? 6'($urandom) : op, rdy);
                @(negedge clk);
                if (c == 0) chk($sformatf("rnd%0d_start_state", k), 32'(bus.state_o), 32'd1);
                n_done += int'(bus.instr_done_o);
                n_ill  += int'(bus.illegal_o);
                n_rw   += int'(bus.RegWrite_o);
                n_mw   += int'(bus.MemWrite_o);
                n_mr   += int'(bus.MemRead_o);
                n_both += int'(bus.MemRead_o & bus.MemWrite_o);
                n_early_rw += int'(bus.RegWrite_o && (bus.state_o == 4'd1 || bus.state_o == 4'd2));
                if (c == len - 1) last_done = int'(bus.instr_done_o);
                if (bus.illegal_o) ill_at = c;
                next_cycle();
            end
            chk($sformatf("rnd%0d_op%0d_done_cnt", k, op), 32'(n_done), legal ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d_op%0d_done_last", k, op), 32'(last_done), legal ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d_op%0d_illegal_at", k, op), 32'(ill_at), legal ? 32'hffffffff : 32'(fs + 1));
            chk($sformatf("rnd%0d_op%0d_illegal_cnt", k, op), 32'(n_ill), legal ? 32'd0 : 32'd1);
            chk($sformatf("rnd%0d_op%0d_regwrite", k, op), 32'(n_rw), 32'(exp_rw));
            chk($sformatf("rnd%0d_op%0d_memwrite", k, op), 32'(n_mw), 32'(exp_mw));
            chk($sformatf("rnd%0d_op%0d_memread", k, op), 32'(n_mr), 32'(exp_mr));
            chk($sformatf("rnd%0d_op%0d_rd_wr_overlap", k, op), 32'(n_both + n_early_rw), 32'd0);
        end
        @(negedge clk);
        chk("final_fetch", 32'(bus.state_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_main_ctrl.md
Name: multicycle_main_ctrl

Overview:
- Moore-style main control FSM for the multi-cycle MIPS datapath.
- Sits directly upstream of the ALU controller and drives its 3-bit ALUOp, using the existing encoding:
  - 010 = R-type (decode funct)
  - 001 = sub
  - 101 = add
  - 110 = slt
- Sequences fetch/decode/execute/memory/writeback per opcode and generates all datapath enables.
- Stalls on a single-bit memory-ready handshake.

Parameters:
- ST_W, 4, state register width.
- OP_RTYPE, 6'd0, R-type opcode.
- OP_J, 6'd2, jump opcode.
- OP_BEQ, 6'd4, beq opcode.
- OP_ADDI, 6'd8, addi opcode.
- OP_SLTI, 6'd10, slti opcode.
- OP_LW, 6'd35, lw opcode.
- OP_SW, 6'd43, sw opcode.

Ports:
- clk_i in 1: clock, rising edge.
- rst_i in 1: reset, asynchronous, active-low (0 = reset).
- instr_op_i in 6: opcode from the instruction register (valid from DECODE onward).
- mem_ready_i in 1: memory completes the current access this cycle.
- PCWrite_o out 1: unconditional PC load.
- PCWriteCond_o out 1: PC load if ALU zero.
- IorD_o out 1: memory address select (0 = PC, 1 = ALUOut).
- MemRead_o out 1: memory read request.
- MemWrite_o out 1: memory write request.
- IRWrite_o out 1: IR load.
- MemtoReg_o out 1: writeback select (1 = MDR).
- RegDst_o out 1: destination select (1 = rd).
- RegWrite_o out 1: register file write.
- ALUSrcA_o out 1: ALU A select (0 = PC, 1 = rs).
- ALUSrcB_o out 2: ALU B select (00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2).
- PCSource_o out 2: next-PC select (00 = ALU, 01 = ALUOut, 10 = jump target).
- ALUOp_o out 3: to the ALU controller.
- instr_done_o out 1: one-cycle pulse on an instruction's final cycle.
- illegal_o out 1: one-cycle pulse on an unknown opcode.
- state_o out 4: current state, for debug.

Behaviour:
- States: RESET=0, FETCH=1, DECODE=2, MEMADDR=3, MEMRD=4, MEMWB=5, MEMWR=6, REX=7, RWB=8, BRANCH=9, JUMP=10, IEX=11, IWB=12.
- Reset:
  - rst_i=0 forces state to RESET immediately (asynchronous), including mid-instruction and mid-stall.
  - In RESET all outputs are 0; state_o=0.
  - First clock edge with rst_i=1 moves to FETCH.
- Any output not listed for a state is 0. ALUOp_o=000 when the ALU is unused.
- FETCH:
  - MemRead=1, IorD=0, SrcA=0, SrcB=01, ALUOp=101.
  - IRWrite=PCWrite=mem_ready_i, PCSource=00.
  - Stay in FETCH while mem_ready_i=0; go to DECODE when it is 1.
- DECODE:
  - SrcA=0, SrcB=11, ALUOp=101 (branch target into ALUOut).
  - Next state by opcode: lw/sw -> MEMADDR; R -> REX; beq -> BRANCH; j -> JUMP; addi/slti -> IEX.
  - Any other opcode: illegal_o=1 and next state is FETCH.
- MEMADDR:
  - SrcA=1, SrcB=10, ALUOp=101.
  - Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD:
  - MemRead=1, IorD=1.
  - Wait while mem_ready_i=0; go to MEMWB when it is 1.
- MEMWB:
  - RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1.
  - Next: FETCH.
- MEMWR:
  - MemWrite=1, IorD=1.
  - Hold until mem_ready_i=1; in that cycle instr_done=1 and next state is FETCH.
- REX: SrcA=1, SrcB=00, ALUOp=010. Next: RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next: FETCH.
- BRANCH:
  - SrcA=1, SrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01, instr_done=1.
  - Next: FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Next: FETCH.
- IEX:
  - SrcA=1, SrcB=10.
  - ALUOp=101 for addi, 110 for slti.
  - Next: IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Next: FETCH.
- Latency with zero stall cycles:
  - lw: 5 cycles.
  - sw, R-type, addi, slti: 4 cycles.
  - beq, j: 3 cycles.
  - Each cycle with mem_ready_i=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Outputs are combinational from state. The only Mealy terms are mem_ready_i (in FETCH and MEMWR) and instr_op_i (in DECODE and IEX).
- MemRead_o and MemWrite_o are never both 1. RegWrite_o is never asserted in FETCH or DECODE.
- instr_op_i changing while in FETCH has no effect.
- Unused encodings 13–15: outputs 0, next state FETCH.

Decomposition:
- Shared package/header `mips_defs`:
  - opcode constants.
  - ALUOp codes (ALUOP_RTYPE=3'b010, ALUOP_SUB=3'b001, ALUOP_ADD=3'b101, ALUOP_SLT=3'b110), so this block and the ALU controller agree.
  - State encodings.
  - ALUSrcB and PCSource select codes.
- No sub-module. The design is one state register, one next-state block and one output-decode block.

Test Plan:
- Reset: rst_i=0 for 2 cycles, then release.
  - state_o=0 and all outputs 0 during reset.
  - state_o=1 after the first edge.
  - With mem_ready_i=1: MemRead_o=1, ALUOp_o=101, PCWrite_o=IRWrite_o=1.
- lw, op=35, mem_ready_i=1 throughout:
  - States visited: 1,2,3,4,5,1.
  - ALUOp_o 101 in MEMADDR.
  - RegWrite_o=MemtoReg_o=1 and instr_done_o=1 only in cycle 5.
- R-type, op=0, then slti, op=10:
  - REX drives ALUOp_o=010 with SrcB=00; RWB has RegDst_o=1.
  - IEX drives ALUOp_o=110 with SrcB=10.
  - Each instruction takes 4 cycles.
- beq, op=4, then j, op=2:
  - BRANCH has ALUOp_o=001, PCWriteCond_o=1, PCSource_o=01.
  - JUMP has PCWrite_o=1, PCSource_o=10.
  - 3 cycles each.
- Stalls:
  - sw with mem_ready_i=0 for 3 cycles in MEMWR: MemWrite_o held high 4 cycles; instr_done_o only on the ready cycle; 7 cycles total.
  - FETCH stall of 2 cycles: IRWrite_o=0 until the ready cycle.
- Illegal and reset mid-operation:
  - op=6'd63: illegal_o pulses in DECODE, next state FETCH, no RegWrite/MemWrite.
  - rst_i dropped mid-MEMRD (asynchronously, between edges): state_o=0 and outputs 0 immediately.
